// File: rtl/lfsr_encrypt_engine.sv
// lfsr_encrypt_engine
//   Stream-encrypts a 64-byte DataMem region. It first writes a preamble of P
//   LFSR-whitened spaces, then XORs plaintext bytes with the running 7-bit LFSR
//   state. The LFSR advances once after every ciphertext write.
//
// Parameters
//   MSG_BASE  DataMem address of plaintext byte 0
//   CT_BASE   DataMem address of ciphertext byte 0 (64-byte region)
//
// Ports
//   Clk         rising-edge clock
//   Reset       synchronous, active-low reset
//   Start       one-cycle request; it is sampled only in IDLE
//   Seed        initial LFSR state (0 is replaced by 7'h01)
//   TapPattern  LFSR tap mask (used when ENC_TAPLOAD_EN is undefined)
//   TapSel      tap-table index (used when ENC_TAPLOAD_EN is defined)
//   PreLen      requested preamble length; it is clamped to 9..15
//   MemRdData   DataMem read data, valid in the same cycle as MemAddr
//   MemAddr     DataMem address
//   MemWrData   DataMem write data; bit 7 is 0 because DataMem adds parity
//   MemWrEn     DataMem write enable
//   Busy        high in every state except IDLE
//   Done        one-cycle completion pulse
//
// Build option
//   ENC_TAPLOAD_EN  When defined, a FETCH state reads the taps from DataMem
//                   address 130 + min(TapSel, 8) instead of using TapPattern.
//
// All outputs are registered. Each transition computes the outputs that
// belong to the state being entered.

module lfsr_encrypt_engine #(
  parameter int MSG_BASE = 0,
  parameter int CT_BASE  = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [6:0] Seed,
  input  logic [6:0] TapPattern,
  input  logic [3:0] TapSel,
  input  logic [3:0] PreLen,
  input  logic [7:0] MemRdData,
  output logic [7:0] MemAddr,
  output logic [7:0] MemWrData,
  output logic       MemWrEn,
  output logic       Busy,
  output logic       Done
);

  localparam logic [7:0] MSG_A = 8'(MSG_BASE);
  localparam logic [7:0] CT_A  = 8'(CT_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef ENC_TAPLOAD_EN
    S_FETCH,
`endif
    S_PRE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] taps_q, taps_d;
  logic [3:0] p_q, p_d;        // effective preamble length
  logic [3:0] k_q, k_d;        // preamble character index
  logic [5:0] j_q, j_d;        // plaintext character index
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [3:0] pre_len_eff;
  logic [6:0] seed_eff;

  function automatic logic [6:0] lfsr_adv(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  assign pre_len_eff = (PreLen < 4'd9) ? 4'd9 : PreLen;
  assign seed_eff    = (Seed == 7'd0) ? 7'h01 : Seed;

`ifdef ENC_TAPLOAD_EN
  logic [3:0] tap_idx;
  assign tap_idx = (TapSel > 4'd8) ? 4'd8 : TapSel;
  logic unused_ok;
  assign unused_ok = ^{MemRdData[7], TapPattern};
`else
  logic unused_ok;
  assign unused_ok = ^{MemRdData[7], TapSel};
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    taps_d  = taps_q;
    p_d     = p_q;
    k_d     = k_q;
    j_d     = j_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          lfsr_d = seed_eff;
          p_d    = pre_len_eff;
          k_d    = 4'd0;
          j_d    = 6'd0;
          busy_d = 1'b1;
`ifdef ENC_TAPLOAD_EN
          state_d = S_FETCH;
          addr_d  = 8'd130 + {4'd0, tap_idx};
          data_d  = 8'd0;
`else
          taps_d  = TapPattern;
          state_d = S_PRE;
          addr_d  = CT_A;
          data_d  = {1'b0, 7'h20 ^ seed_eff};
          we_d    = 1'b1;
`endif
        end
      end

`ifdef ENC_TAPLOAD_EN
      S_FETCH: begin
        taps_d  = MemRdData[6:0];
        state_d = S_PRE;
        addr_d  = CT_A;
        data_d  = {1'b0, 7'h20 ^ lfsr_q};
        we_d    = 1'b1;
      end
`endif

      S_PRE: begin
        lfsr_d = lfsr_adv(lfsr_q, taps_q);
        if (k_q == p_q - 4'd1) begin
          // The last preamble write is under way, so set up the first plaintext read.
          state_d = S_RD;
          addr_d  = MSG_A + {2'd0, j_q};
          data_d  = 8'd0;
        end else begin
          k_d    = k_q + 4'd1;
          addr_d = CT_A + {4'd0, k_q} + 8'd1;
          data_d = {1'b0, 7'h20 ^ lfsr_d};
          we_d   = 1'b1;
        end
      end

      S_RD: begin
        state_d = S_WR;
        data_d  = {1'b0, MemRdData[6:0] ^ lfsr_q};
        addr_d  = CT_A + {4'd0, p_q} + {2'd0, j_q};
        we_d    = 1'b1;
      end

      S_WR: begin
        lfsr_d = lfsr_adv(lfsr_q, taps_q);
        if ({4'd0, p_q} + {2'd0, j_q} == 8'd63) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          addr_d  = 8'd0;
          data_d  = 8'd0;
        end else begin
          j_d     = j_q + 6'd1;
          state_d = S_RD;
          addr_d  = MSG_A + {2'd0, j_q} + 8'd1;
          data_d  = 8'd0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        addr_d  = 8'd0;
        data_d  = 8'd0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        addr_d  = 8'd0;
        data_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= 7'd0;
      taps_q  <= 7'd0;
      p_q     <= 4'd0;
      k_q     <= 4'd0;
      j_q     <= 6'd0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      taps_q  <= taps_d;
      p_q     <= p_d;
      k_q     <= k_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign MemAddr   = addr_q;
  assign MemWrData = data_q;
  assign MemWrEn   = we_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Bench for lfsr_encrypt_engine. A behavioural model builds the 64-byte
// ciphertext and the cycle schedule for each run. A negedge monitor compares
// Busy, Done, MemWrEn, MemAddr and MemWrData against that model on every cycle
// of the run. Literal values pin the model and the key boundary cases.

module tb_lfsr_encrypt_engine;

`ifdef ENC_TAPLOAD_EN
  localparam int F_M = 1;
`else
  localparam int F_M = 0;
`endif

  logic       Clk = 1'b0;
  logic       Reset, Start;
  logic [6:0] Seed, TapPattern;
  logic [3:0] TapSel, PreLen;
  logic [7:0] MemRdData, MemAddr, MemWrData;
  logic       MemWrEn, Busy, Done;

  lfsr_encrypt_engine #(.MSG_BASE(0), .CT_BASE(64)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Seed(Seed), .TapPattern(TapPattern),
    .TapSel(TapSel), .PreLen(PreLen), .MemRdData(MemRdData), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemWrEn(MemWrEn), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DataMem model: plaintext at 0..63, tap table at 130..138, RAM elsewhere.
  function automatic logic [7:0] pt(input int a);
    return 8'(a * 37 + 5);
  endfunction

  function automatic logic [7:0] tap_rom(input int k);
    case (k)
      0:       return 8'h60;
      1:       return 8'h41;
      2:       return 8'hF8;   // bit 7 is the parity bit, so the taps are 7'h78
      default: return 8'(8'h0C + k);
    endcase
  endfunction

  logic [7:0] ct_mem [0:255];

  always_comb begin
    MemRdData = 8'h00;
    if (int'(MemAddr) < 64) MemRdData = pt(int'(MemAddr));
    else if (int'(MemAddr) >= 130 && int'(MemAddr) <= 138) MemRdData = tap_rom(int'(MemAddr) - 130);
    else MemRdData = ct_mem[MemAddr];
  end

  always @(posedge Clk) if (MemWrEn) ct_mem[MemAddr] <= MemWrData;

  // Behavioural model of one run.
  logic [6:0] exp_data [64];
  int         p_m, lat_m;
  logic [7:0] m_fetch_addr;

  task automatic build_model(input logic [6:0] seed, input logic [6:0] taps,
                             input logic [3:0] prelen, input logic [3:0] tsel);
    logic [6:0] s;
    logic [7:0] b;
    p_m = (int'(prelen) < 9) ? 9 : int'(prelen);
    s = (seed == 7'd0) ? 7'h01 : seed;
    for (int i = 0; i < 64; i++) begin
      b = (i < p_m) ? 8'h20 : pt(i - p_m);
      exp_data[i] = b[6:0] ^ s;
      s = {s[5:0], ^(s & taps)};
    end
    lat_m = 1 + F_M + p_m + 2 * (64 - p_m);
    m_fetch_addr = 8'(130 + ((int'(tsel) > 8) ? 8 : int'(tsel)));
  endtask

  // Per-cycle compare process.
  logic armed = 1'b0;
  int cyc, wr_cnt, done_cyc, last_wr_addr;

  always @(negedge Clk) begin
    int c2, r;
    logic exp_we, exp_rd;
    int idx;
    if (!armed && Reset === 1'b1 && Start === 1'b1 && Busy === 1'b0) begin
      armed = 1'b1; cyc = 0; wr_cnt = 0; done_cyc = -1; last_wr_addr = -1;
    end
    if (armed) begin
      c2 = cyc - 1 - F_M;
      exp_we = 1'b0; exp_rd = 1'b0; idx = 0;
      if (c2 >= 0 && c2 < p_m) begin
        exp_we = 1'b1; idx = c2;
      end else if (c2 >= p_m && c2 < 128 - p_m) begin
        r = c2 - p_m;
        if (r % 2 == 1) begin exp_we = 1'b1; idx = p_m + r / 2; end
        else begin exp_rd = 1'b1; idx = r / 2; end
      end
      chk("busy", 32'(Busy), 32'(cyc >= 1 && cyc <= lat_m));
      chk("done", 32'(Done), 32'(cyc == lat_m));
      chk("wr_en", 32'(MemWrEn), 32'(exp_we));
      if (exp_we) begin
        chk("wr_addr", 32'(MemAddr), 32'(64 + idx));
        chk("wr_data", 32'(MemWrData), 32'({1'b0, exp_data[idx]}));
      end
      if (exp_rd) chk("rd_addr", 32'(MemAddr), 32'(idx));
      if (F_M == 1 && cyc == 1) chk("fetch_addr", 32'(MemAddr), 32'(m_fetch_addr));
      if (MemWrEn) begin wr_cnt++; last_wr_addr = int'(MemAddr); end
      if (Done) done_cyc = cyc;
      cyc++;
      if (cyc > lat_m || Reset !== 1'b1) armed = 1'b0;
    end
  end

  task automatic kick(input logic [6:0] seed, input logic [6:0] taps,
                      input logic [3:0] tsel, input logic [3:0] prelen);
    logic [7:0] t8;
    logic [6:0] mt;
`ifdef ENC_TAPLOAD_EN
    t8 = tap_rom((int'(tsel) > 8) ? 8 : int'(tsel));
    mt = t8[6:0];
`else
    t8 = 8'd0;
    mt = taps;
`endif
    build_model(seed, mt, prelen, tsel);
    @(posedge Clk); #1;
    Seed = seed; TapPattern = taps; TapSel = tsel; PreLen = prelen; Start = 1'b1;
    @(posedge Clk); #1;
    // Scramble the inputs so that only the values latched at Start can matter.
    Start = 1'b0; Seed = ~seed; TapPattern = ~taps; TapSel = ~tsel; PreLen = ~prelen;
  endtask

  task automatic run(input logic [6:0] seed, input logic [6:0] taps, input logic [3:0] tsel,
                     input logic [3:0] prelen, input int restart_at);
    int c, errs;
    kick(seed, taps, tsel, prelen);
    c = 1;
    while (armed && c < 400) begin
      Start = (c == restart_at);
      @(posedge Clk); #1;
      c++;
    end
    Start = 1'b0;
    if (armed) begin
      chk("run_timeout", 32'd1, 32'd0);
      armed = 1'b0;
    end
    chk("wr_count", 32'(wr_cnt), 32'd64);
    chk("done_latency", 32'(done_cyc), 32'(lat_m));
    errs = 0;
    for (int i = 0; i < 64; i++)
      if (ct_mem[64 + i] !== {1'b0, exp_data[i]}) errs++;
    chk("ct_region", 32'(errs), 32'd0);
  endtask

  initial begin
    int errs, n;
    Reset = 1'b0; Start = 1'b0; Seed = 7'd0; TapPattern = 7'd0; TapSel = 4'd0; PreLen = 4'd0;
    p_m = 9; lat_m = 0; m_fetch_addr = 8'd0;
    for (int i = 0; i < 256; i++) ct_mem[i] = 8'h00;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_wr_en", 32'(MemWrEn), 32'd0);
    chk("rst_addr", 32'(MemAddr), 32'd0);
    chk("rst_wr_data", 32'(MemWrData), 32'd0);
    @(posedge Clk); #1; Reset = 1'b1;

    // Pin the model with hand-computed values.
    build_model(7'h01, 7'h60, 4'd9, 4'd0);
    chk("model_ct0", 32'(exp_data[0]), 32'h21);
    chk("model_ct1", 32'(exp_data[1]), 32'h22);
    build_model(7'h01, 7'h60, 4'd3, 4'd0);
    chk("model_p_clamp", 32'(p_m), 32'd9);
    chk("model_latency", 32'(lat_m), 32'(120 + F_M));

    // Taps 7'h60, Seed 1, PreLen 9.
    run(7'h01, 7'h60, 4'd0, 4'd9, -1);
    chk("lit_addr64", 32'(ct_mem[64]), 32'h21);
    chk("lit_addr65", 32'(ct_mem[65]), 32'h22);

    // PreLen 3 is clamped to 9; the last write is at 127 and Done comes 120 cycles after Start.
    run(7'h01, 7'h60, 4'd0, 4'd3, -1);
    chk("lit_last_wr", 32'(last_wr_addr), 32'd127);
    chk("lit_done_cyc", 32'(done_cyc), 32'(120 + F_M));

    // A zero seed is replaced by 1.
    for (int i = 64; i < 128; i++) ct_mem[i] = 8'hEE;
    run(7'h00, 7'h60, 4'd0, 4'd12, -1);
    chk("lit_seed0", 32'(ct_mem[64]), 32'h21);

    // Start pulsed while Busy has no effect; maximum preamble length.
    run(7'h5A, 7'h41, 4'd1, 4'd15, 30);
    // All-ones seed and taps.
    run(7'h7F, 7'h7F, 4'd12, 4'd10, -1);
    // Tap-table case (TapSel 2 gives taps 7'h78).
    run(7'h13, 7'h78, 4'd2, 4'd11, -1);

    // Reset asserted in the cycle after the 20th write.
    kick(7'h33, 7'h60, 4'd0, 4'd9);
    n = 0;
    while (wr_cnt < 20 && n < 200) begin @(posedge Clk); #1; n++; end
    chk("abort_reach20", 32'(wr_cnt >= 20), 32'd1);
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_no_wr_now", 32'(MemWrEn), 32'd0);
    @(posedge Clk); #1; Reset = 1'b1;
    @(negedge Clk);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_addr", 32'(MemAddr), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      if (MemWrEn !== 1'b0 || Busy !== 1'b0) errs++;
      @(negedge Clk);
    end
    chk("abort_quiet", 32'(errs), 32'd0);
    armed = 1'b0;
    // Restart after the abort begins again from character 0.
    run(7'h33, 7'h60, 4'd0, 4'd9, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_encrypt_engine.md
LFSR_ENCRYPT_ENGINE -- requirements
Module: lfsr_encrypt_engine

Interface
REQ-001 Parameter MSG_BASE, default 0, SHALL be the DataMem address of plaintext byte 0.
REQ-002 Parameter CT_BASE, default 64, SHALL be the DataMem address of ciphertext byte 0; the ciphertext region is 64 bytes long.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  SHALL be a synchronous, active-low reset (0 = reset).
REQ-005 Start  input  1  SHALL be a one-cycle request to begin encryption, sampled only in IDLE.
REQ-006 Seed  input  7  SHALL be the initial LFSR state.
REQ-007 TapPattern  input  7  SHALL be the LFSR tap mask when ENC_TAPLOAD_EN is undefined.
REQ-008 TapSel  input  4  SHALL be the tap-table index when ENC_TAPLOAD_EN is defined.
REQ-009 PreLen  input  4  SHALL be the requested preamble length in characters.
REQ-010 MemRdData  input  8  SHALL be DataMem DataOut; the read is combinational, same cycle as the address.
REQ-011 MemAddr  output  8  SHALL drive DataMem DataAddress.
REQ-012 MemWrData  output  8  SHALL drive DataMem DataIn; bit 7 is always 0 because DataMem inserts parity.
REQ-013 MemWrEn  output  1  SHALL drive DataMem WriteEn.
REQ-014 Busy  output  1  SHALL be high in every state except IDLE.
REQ-015 Done  output  1  SHALL be a one-cycle pulse marking completion.

Function
REQ-016 States SHALL be: IDLE, FETCH (present only with ENC_TAPLOAD_EN), PRE, RD, WR, DONE.
REQ-017 IDLE with Start=1 SHALL latch Seed, PreLen and taps, then go to FETCH if compiled in, otherwise to PRE.
REQ-018 Start SHALL be ignored in every state except IDLE.
REQ-019 Effective preamble length P SHALL be PreLen clamped to the range 9..15.
REQ-020 A latched Seed of 0 SHALL be replaced by 7'h01 so the LFSR cannot lock up.
REQ-021 LFSR advance SHALL be lfsr <= {lfsr[5:0], ^(lfsr & taps)}, applied once after each ciphertext write.
REQ-022 PRE SHALL write {1'b0, 7'h20 ^ lfsr} to CT_BASE+k for k = 0..P-1, one write per cycle.
REQ-023 After P preamble writes, control SHALL pass to RD.
REQ-024 RD SHALL drive MemAddr = MSG_BASE+j with MemWrEn=0, and register MemRdData[6:0] ^ lfsr.
REQ-025 WR SHALL write the registered value to CT_BASE+P+j, then increment j.
REQ-026 j SHALL run over 0..63-P; after the write at CT_BASE+63, control SHALL pass to DONE.
REQ-027 DONE SHALL assert Done for exactly one cycle, then return to IDLE.
REQ-028 Total latency from the Start cycle to Done SHALL be 1 + P + 2*(64-P) cycles, plus 1 with ENC_TAPLOAD_EN.
REQ-029 No address at or above CT_BASE+64 SHALL ever be written.
REQ-030 MemWrEn SHALL be high only in PRE and WR.
REQ-031 Address arithmetic SHALL be 8-bit with no wrap-around for the default parameters.

Reset
REQ-032 With Reset=0 at a clock edge, the block SHALL go to IDLE with Busy=0, Done=0, MemWrEn=0, MemAddr=0, MemWrData=0, lfsr=0 and j=0.
REQ-033 Reset asserted mid-operation SHALL abort the operation at that edge with no further writes; a subsequent Start SHALL restart from character 0.

Configuration
REQ-034 With macro ENC_TAPLOAD_EN defined, FETCH SHALL drive MemAddr = 130 + TapSel (TapSel clamped to 8) for one cycle and latch MemRdData[6:0] as taps; TapPattern SHALL be ignored.
REQ-035 With ENC_TAPLOAD_EN undefined, FETCH SHALL not exist, TapPattern SHALL be latched at Start, and TapSel SHALL be ignored.

Verification
REQ-036 Taps 7'h60, Seed 7'h01, PreLen 9: the first two writes SHALL be addr 64 data 8'h21, then addr 65 data 8'h22.
REQ-037 PreLen 3 SHALL give P = 9, with the first plaintext read at addr 0 and its write at addr 73; the final write SHALL be at addr 127, with Done 120 cycles after Start.
REQ-038 Seed 0 with taps 7'h60 SHALL give a first write at addr 64 of data 8'h21.
REQ-039 Start pulsed again while Busy SHALL have no effect on the write sequence.
REQ-040 Reset=0 asserted in the cycle after the 20th write SHALL produce no further MemWrEn, and Busy SHALL be 0 on the next cycle.
REQ-041 With ENC_TAPLOAD_EN defined, TapSel 2 with DataMem reset SHALL read addr 132, latch taps 7'h78, and produce ciphertext matching a reference model.
